// File: rtl/digital_clock_pkg.sv
// Shared widths and default moduli for the 24-hour digital clock.
package digital_clock_pkg;

   localparam int unsigned SEC_W    = 6;
   localparam int unsigned MIN_W    = 6;
   localparam int unsigned HR_W     = 5;

   localparam int unsigned SEC_MOD  = 60;
   localparam int unsigned MIN_MOD  = 60;
   localparam int unsigned HR_MOD   = 24;

   // Packed time-of-day view used for bundled comparisons
   typedef struct packed {
      logic [HR_W-1:0]  hours;
      logic [MIN_W-1:0] minutes;
      logic [SEC_W-1:0] seconds;
   } hms_t;

endpackage : digital_clock_pkg

// File: rtl/digital_clock_if.sv
// Time-of-day bundle: the three counter values plus the end-of-day carry.
interface digital_clock_if;
   import digital_clock_pkg::*;

   logic [SEC_W-1:0] seconds;
   logic [MIN_W-1:0] minutes;
   logic [HR_W-1:0]  hours;
   logic             day_wrap;

   modport master (output seconds, minutes, hours, day_wrap);
   modport slave  (input  seconds, minutes, hours, day_wrap);

endinterface : digital_clock_if

// File: rtl/mod_n_counter.sv
// Generic modulo-N counter with enable and a combinational carry-out.
module mod_n_counter #(
   parameter int unsigned N = 60,
   parameter int unsigned W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         carry_c
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] count_nxt_c;

   // Next count: out-of-range values collapse to 0, otherwise wrap at N-1
   always_comb begin
      count_nxt_c = count;
      if (count > LAST) begin
         count_nxt_c = '0;
      end else if (en) begin
         count_nxt_c = (count == LAST) ? '0 : count + W'(1);
      end
   end

   // Carry fires on the enabled edge that wraps this stage
   assign carry_c = en && (count == LAST);

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         count <= count_nxt_c;
      end
   end

endmodule : mod_n_counter

// File: rtl/digital_clock.sv
// 24-hour clock: three chained modulo counters advanced by a 1 Hz tick.
module digital_clock
   import digital_clock_pkg::*;
#(
   parameter int unsigned SEC_WRAP  = SEC_MOD,
   parameter int unsigned MIN_WRAP  = MIN_MOD,
   parameter int unsigned HOUR_WRAP = HR_MOD
) (
   input  logic             Clk_1sec,
   input  logic             reset,
   output logic [SEC_W-1:0] seconds,
   output logic [MIN_W-1:0] minutes,
   output logic [HR_W-1:0]  hours
);

   digital_clock_if tod ();

   logic sec_carry_c;
   logic min_carry_c;

   // Seconds stage counts every tick
   mod_n_counter #(.N(SEC_WRAP), .W(SEC_W)) u_sec (
      .clk     (Clk_1sec),
      .rst_n   (reset),
      .en      (1'b1),
      .count   (tod.seconds),
      .carry_c (sec_carry_c)
   );

   // Minutes stage advances on the seconds wrap
   mod_n_counter #(.N(MIN_WRAP), .W(MIN_W)) u_min (
      .clk     (Clk_1sec),
      .rst_n   (reset),
      .en      (sec_carry_c),
      .count   (tod.minutes),
      .carry_c (min_carry_c)
   );

   // Hours stage advances on the minutes wrap
   mod_n_counter #(.N(HOUR_WRAP), .W(HR_W)) u_hr (
      .clk     (Clk_1sec),
      .rst_n   (reset),
      .en      (min_carry_c),
      .count   (tod.hours),
      .carry_c (tod.day_wrap)
   );

   // Outputs come straight from the counter registers
   assign seconds = tod.seconds;
   assign minutes = tod.minutes;
   assign hours   = tod.hours;

endmodule : digital_clock

// File: tb/tb_digital_clock.sv
// Self-checking bench for digital_clock: scoreboarded per-tick model plus
// a vector table of landmark times and hand-written reset sequences.
module tb_digital_clock;
   import digital_clock_pkg::*;

   logic Clk_1sec;
   logic reset;

   digital_clock_if tif ();

   digital_clock dut (
      .Clk_1sec (Clk_1sec),
      .reset    (reset),
      .seconds  (tif.seconds),
      .minutes  (tif.minutes),
      .hours    (tif.hours)
   );

   assign tif.day_wrap = 1'b0;

   initial Clk_1sec = 1'b0;
   always #5 Clk_1sec = ~Clk_1sec;

   typedef struct {
      string       name;
      int unsigned edges;
      int unsigned h;
      int unsigned m;
      int unsigned s;
   } vec_t;

   vec_t        vecs [8];
   hms_t        sb_q [$];
   int          checks;
   int          errors;
   int unsigned n_edges;

   function automatic hms_t mk(input int unsigned h, input int unsigned m, input int unsigned s);
      hms_t r;
      r.hours   = HR_W'(h);
      r.minutes = MIN_W'(m);
      r.seconds = SEC_W'(s);
      return r;
   endfunction

   // Reference: time of day after n ticks since reset
   function automatic hms_t model(input int unsigned n);
      int unsigned t;
      t = n % 86400;
      return mk(t / 3600, (t / 60) % 60, t % 60);
   endfunction

   function automatic hms_t dut_now();
      return mk(32'(tif.hours), 32'(tif.minutes), 32'(tif.seconds));
   endfunction

   task automatic check(input string name, input hms_t act, input hms_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d:%0d:%0d expected %0d:%0d:%0d", name,
                  act.hours, act.minutes, act.seconds,
                  exp.hours, exp.minutes, exp.seconds);
      end
   endtask

   task automatic check_range(input hms_t act);
      checks++;
      if (act.hours > 5'd23 || act.minutes > 6'd59 || act.seconds > 6'd59) begin
         errors++;
         $display("FAIL range at tick %0d: got %0d:%0d:%0d limit 23:59:59",
                  n_edges, act.hours, act.minutes, act.seconds);
      end
   endtask

   // One tick: push the model prediction, sample at the falling edge, compare
   task automatic tick(input bit counting);
      hms_t exp;
      @(posedge Clk_1sec);
      if (counting) n_edges++;
      sb_q.push_back(counting ? model(n_edges) : mk(0, 0, 0));
      @(negedge Clk_1sec);
      exp = sb_q.pop_front();
      check("tick", dut_now(), exp);
      check_range(dut_now());
   endtask

   task automatic advance_to(input int unsigned target);
      while (n_edges < target) tick(1'b1);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      n_edges = 0;

      vecs[0] = '{"first_tick",   1,     0,  0,  1};
      vecs[1] = '{"sec_59",       59,    0,  0,  59};
      vecs[2] = '{"min_wrap",     60,    0,  1,  0};
      vecs[3] = '{"pre_hour",     3599,  0,  59, 59};
      vecs[4] = '{"hour_wrap",    3600,  1,  0,  0};
      vecs[5] = '{"day_end",      86399, 23, 59, 59};
      vecs[6] = '{"day_wrap",     86400, 0,  0,  0};
      vecs[7] = '{"after_wrap",   86401, 0,  0,  1};

      // Hold reset low across several edges: counters stay at zero
      reset = 1'b0;
      repeat (3) tick(1'b0);
      check("reset_hold", dut_now(), mk(0, 0, 0));

      // Release between edges, then walk through a full day and beyond
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         advance_to(vecs[i].edges);
         check(vecs[i].name, dut_now(), mk(vecs[i].h, vecs[i].m, vecs[i].s));
      end

      // Fresh reset, count to 00:05:17
      reset = 1'b0;
      #1;
      check("reset_async_a", dut_now(), mk(0, 0, 0));
      @(negedge Clk_1sec);
      reset   = 1'b1;
      n_edges = 0;
      advance_to(317);
      check("at_05_17", dut_now(), mk(0, 5, 17));

      // Asynchronous reset between edges clears before the next edge
      #1;
      reset = 1'b0;
      #1;
      check("reset_async_b", dut_now(), mk(0, 0, 0));
      tick(1'b0);
      check("reset_held_edge", dut_now(), mk(0, 0, 0));

      // Counting restarts at one second after release
      reset   = 1'b1;
      n_edges = 0;
      tick(1'b1);
      check("restart", dut_now(), mk(0, 0, 1));

      // Reset asserted around a minute-wrap edge wins over the wrap
      advance_to(59);
      @(posedge Clk_1sec);
      #1;
      reset = 1'b0;
      #1;
      check("reset_on_wrap", dut_now(), mk(0, 0, 0));
      @(negedge Clk_1sec);
      reset   = 1'b1;
      n_edges = 0;
      tick(1'b1);
      check("restart_after_wrap", dut_now(), mk(0, 0, 1));

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_digital_clock

// File: doc/digital_clock.md
DIGITAL_CLOCK -- requirements
Module: digital_clock

Interface
REQ-001 Parameter: SEC_WRAP, default 60, seconds modulus.
REQ-002 Parameter: MIN_WRAP, default 60, minutes modulus.
REQ-003 Parameter: HOUR_WRAP, default 24, hours modulus (24-hour format).
REQ-004 The port list SHALL be exactly as follows:
- Clk_1sec  input  1  one clock; 1 Hz tick; all state on its rising edge.
- reset  input  1  asynchronous, active-low; low clears all counters.
- seconds  output  6  current seconds, 0..SEC_WRAP-1.
- minutes  output  6  current minutes, 0..MIN_WRAP-1.
- hours  output  5  current hours, 0..HOUR_WRAP-1.
REQ-005 All outputs SHALL be driven directly from registers, with no combinational path from any input.

Function
REQ-006 Each rising edge of Clk_1sec with reset high SHALL advance the time by exactly one second.
REQ-007 The seconds increment SHALL be visible on the outputs immediately after the edge, i.e. 1-cycle latency.
REQ-008 When seconds < SEC_WRAP-1, seconds SHALL become seconds+1, and minutes and hours SHALL hold.
REQ-009 When seconds = SEC_WRAP-1, seconds SHALL wrap to 0 and minutes SHALL advance by one, all on the same edge.
REQ-010 On the edge where seconds = SEC_WRAP-1 and minutes = MIN_WRAP-1, minutes SHALL wrap to 0 and hours SHALL advance by one.
REQ-011 The terminal time HOUR_WRAP-1 : MIN_WRAP-1 : SEC_WRAP-1 (23:59:59) SHALL wrap to 00:00:00 on the next edge.
REQ-012 No output SHALL ever hold a value at or above its modulus; any such value SHALL be forced to 0 on the next edge.
REQ-013 Arithmetic: each counter SHALL be unsigned, compared against modulus-1, and never allowed to overflow its port width.

Reset
REQ-014 reset low SHALL clear seconds, minutes and hours to 0 immediately, without waiting for a clock edge.
REQ-015 Counters SHALL hold 0 for as long as reset stays low.
REQ-016 The first rising edge after reset returns high SHALL produce seconds = 1.
REQ-017 Reset asserted mid-count, including during a wrap edge, SHALL take priority over counting and clear all counters to 0.

Structure
REQ-018 A shared package digital_clock_pkg SHALL hold:
- the width constants: SEC_W = 6, MIN_W = 6, HR_W = 5;
- the default moduli: 60, 60, 24.
REQ-019 A single generic sub-module mod_n_counter SHALL be instantiated three times, chained through carry signals. Its ports:
- clock, active-low async reset, enable (increment) input;
- count output;
- carry output, asserted when count = N-1 and enable is high.
REQ-020 The seconds counter SHALL have enable tied high; each higher stage SHALL be enabled by the carry of the stage below.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Hold reset low, then release it and apply 1 edge -> 00:00:00 during reset, then seconds = 1.
- Apply 59 edges after reset -> 00:00:59; the 60th edge -> seconds = 0, minutes = 1, hours = 0.
- Apply 3600 edges after reset -> 01:00:00, with seconds and minutes = 0 on that same edge.
- Apply 86399 edges after reset -> 23:59:59; the next edge -> 00:00:00.
- Pull reset low asynchronously between edges at 00:05:17 -> all outputs 0 before the next edge; counting restarts at 1 after release.
- Across a full 24 h run, every sample -> seconds ≤ 59, minutes ≤ 59, hours ≤ 23.
